// File: rtl/riscv_types.sv
// riscv_types: shared types for the FP execution pipelines and their
// completion-side collector.
//   exe_p_mux_bus_type : pipeline control signals that travel with a result
//   FP_COLLECT_UNITS   : default number of FP units drained by the collector
package riscv_types;

  localparam int FP_COLLECT_UNITS = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        reg_write;
    logic        FP_reg_write;
  } exe_p_mux_bus_type;

endpackage

// File: rtl/fp_result_collector_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req : request vector, one bit per requester
//   ptr : index where the scan starts (highest priority this cycle)
//   gnt : one-hot grant, all zero when no request
//   idx : binary index of the granted requester, 0 when no request
// The pointer register lives in the instantiating block.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  // Scan requests starting at ptr, wrapping modulo N; first hit wins.
  always_comb begin
    logic [W:0]   pos;
    logic [W-1:0] j;
    logic         found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (W+1)'(k);
      if (pos >= (W+1)'(N)) begin
        pos = pos - (W+1)'(N);
      end else begin
        pos = pos;
      end
      j = pos[W-1:0];
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        idx    = j;
        found  = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fp_result_collector.sv
// fp_result_collector: drains up to N_UNITS pipelined FP units through
// one-entry hold registers onto a single round-robin writeback port.
//   clk, rst            : clock, synchronous active-low reset
//   unit_valid/result/bus : completion outputs of each unit
//   unit_en             : advance enable back to each unit (back-pressure)
//   unit_clear          : per-unit clear vector, driven by flush
//   flush               : kill all held and in-flight FP work
//   wb_ready/valid/result/bus : writeback handshake and payload
//   hold_rd, hold_reg_write, hold_FP_reg_write : held destinations for hazards
//   busy                : at least one hold entry valid
module fp_result_collector
  import riscv_types::*;
#(
  parameter int N_UNITS = FP_COLLECT_UNITS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_UNITS-1:0]                unit_valid,
  input  logic [N_UNITS-1:0][31:0]          unit_result,
  input  exe_p_mux_bus_type [N_UNITS-1:0]   unit_bus,
  output logic [N_UNITS-1:0]                unit_en,
  output logic [N_UNITS-1:0][2:0]           unit_clear,
  input  logic                              flush,
  input  logic                              wb_ready,
  output logic                              wb_valid,
  output logic [31:0]                       wb_result,
  output exe_p_mux_bus_type                 wb_bus,
  output logic [N_UNITS-1:0][4:0]           hold_rd,
  output logic [N_UNITS-1:0]                hold_reg_write,
  output logic [N_UNITS-1:0]                hold_FP_reg_write,
  output logic                              busy
);

  localparam int IDX_W = $clog2(N_UNITS);

  logic [N_UNITS-1:0]              hv_q, hv_d;
  logic [N_UNITS-1:0][31:0]        hres_q, hres_d;
  exe_p_mux_bus_type [N_UNITS-1:0] hbus_q, hbus_d;
  logic [IDX_W-1:0]                rr_q, rr_d;

  logic [N_UNITS-1:0] arb_gnt_s;
  logic [IDX_W-1:0]   sel_s;
  logic [N_UNITS-1:0] grant_s;
  logic [N_UNITS-1:0] capture_s;

  rr_arbiter #(.N(N_UNITS), .W(IDX_W)) u_arb (
    .req (hv_q),
    .ptr (rr_q),
    .gnt (arb_gnt_s),
    .idx (sel_s)
  );

  // Writeback handshake, back-pressure and capture qualification.
  always_comb begin
    wb_valid  = (|hv_q) & ~flush;
    grant_s   = (wb_valid & wb_ready) ? arb_gnt_s : '0;
    // A held entry frees its unit only in the cycle it is granted.
    unit_en   = ~hv_q | grant_s;
    capture_s = flush ? '0 : (unit_valid & unit_en);
    busy      = |hv_q;
    if (wb_valid) begin
      wb_result = hres_q[sel_s];
      wb_bus    = hbus_q[sel_s];
    end else begin
      wb_result = 32'd0;
      wb_bus    = '0;
    end
  end

  // Next-state for hold entries and the round-robin pointer.
  always_comb begin
    hres_d = hres_q;
    hbus_d = hbus_q;
    if (flush) begin
      hv_d = '0;
    end else begin
      // Grant and capture together refill the entry without a bubble.
      hv_d = (hv_q & ~grant_s) | capture_s;
    end
    for (int i = 0; i < N_UNITS; i++) begin
      if (capture_s[i]) begin
        hres_d[i] = unit_result[i];
        hbus_d[i] = unit_bus[i];
      end else begin
        hres_d[i] = hres_q[i];
        hbus_d[i] = hbus_q[i];
      end
    end
    if (|grant_s) begin
      if (sel_s == IDX_W'(N_UNITS - 1)) begin
        rr_d = '0;
      end else begin
        rr_d = sel_s + IDX_W'(1);
      end
    end else begin
      rr_d = rr_q;
    end
  end

  // Per-unit clear fan-out and hazard view of the hold registers.
  always_comb begin
    for (int i = 0; i < N_UNITS; i++) begin
      unit_clear[i]        = {3{flush}};
      hold_rd[i]           = hbus_q[i].rd;
      hold_reg_write[i]    = hv_q[i] & hbus_q[i].reg_write;
      hold_FP_reg_write[i] = hv_q[i] & hbus_q[i].FP_reg_write;
    end
  end

  // Hold-entry and pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hv_q   <= '0;
      hres_q <= '0;
      hbus_q <= '0;
      rr_q   <= '0;
    end else begin
      hv_q   <= hv_d;
      hres_q <= hres_d;
      hbus_q <= hbus_d;
      rr_q   <= rr_d;
    end
  end

endmodule

// File: tb/tb_fp_result_collector.sv
// Testbench for fp_result_collector: per-unit source queues model the FP
// units (a unit advances only when its datum is captured), expected
// writebacks go into a scoreboard queue, and a monitor pops and compares on
// every accepted writeback.
module tb_fp_result_collector;
  import riscv_types::*;

  localparam int N = 4;

  typedef struct packed {
    logic [31:0]       res;
    exe_p_mux_bus_type bus;
  } item_t;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic [N-1:0]                unit_valid;
  logic [N-1:0][31:0]          unit_result;
  exe_p_mux_bus_type [N-1:0]   unit_bus;
  logic [N-1:0]                unit_en;
  logic [N-1:0][2:0]           unit_clear;
  logic                        flush = 1'b0;
  logic                        wb_ready = 1'b0;
  logic                        wb_valid;
  logic [31:0]                 wb_result;
  exe_p_mux_bus_type           wb_bus;
  logic [N-1:0][4:0]           hold_rd;
  logic [N-1:0]                hold_reg_write;
  logic [N-1:0]                hold_FP_reg_write;
  logic                        busy;

  item_t src_q [N][$];
  item_t exp_q [$];
  int compared   = 0;
  int mismatched = 0;

  fp_result_collector #(.N_UNITS(N)) dut (
    .clk               (clk),
    .rst               (rst),
    .unit_valid        (unit_valid),
    .unit_result       (unit_result),
    .unit_bus          (unit_bus),
    .unit_en           (unit_en),
    .unit_clear        (unit_clear),
    .flush             (flush),
    .wb_ready          (wb_ready),
    .wb_valid          (wb_valid),
    .wb_result         (wb_result),
    .wb_bus            (wb_bus),
    .hold_rd           (hold_rd),
    .hold_reg_write    (hold_reg_write),
    .hold_FP_reg_write (hold_FP_reg_write),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input int u, input logic [31:0] r, input logic [4:0] rd, input bit wb);
    item_t it;
    it.res              = r;
    it.bus.pc           = {r[15:0], 16'h0100};
    it.bus.rd           = rd;
    it.bus.reg_write    = 1'b1;
    it.bus.FP_reg_write = 1'b1;
    src_q[u].push_back(it);
    if (wb) exp_q.push_back(it);
  endtask

  // Unit models: present queue head; pop it once captured; clear on flush/reset.
  initial begin
    logic [N-1:0] cap;
    logic         kill;
    unit_valid  = '0;
    unit_result = '0;
    unit_bus    = '0;
    forever begin
      @(negedge clk);
      cap  = unit_valid & unit_en;
      kill = flush | ~rst;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (kill) src_q[i].delete();
        else if (cap[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          unit_valid[i]  = 1'b1;
          unit_result[i] = src_q[i][0].res;
          unit_bus[i]    = src_q[i][0].bus;
        end else begin
          unit_valid[i]  = 1'b0;
          unit_result[i] = 32'd0;
          unit_bus[i]    = '0;
        end
      end
    end
  end

  // Scoreboard monitor: every accepted writeback must match the next expected item.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (rst && wb_valid && wb_ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL wb_unexpected: got result %h rd %0d, nothing expected", wb_result, wb_bus.rd);
        end else begin
          it = exp_q.pop_front();
          if (wb_result !== it.res || wb_bus !== it.bus) begin
            mismatched++;
            $display("FAIL wb_data: got result %h bus %h, expected result %h bus %h",
                     wb_result, wb_bus, it.res, it.bus);
          end
        end
      end
    end
  end

  initial begin
    // Reset state.
    tick();
    tick();
    #1;
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_unit_en", 64'(unit_en), 64'hF);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_clear", 64'(unit_clear), 64'd0);
    check("rst_hold_flags", 64'({hold_reg_write, hold_FP_reg_write}), 64'd0);
    check("rst_rr", 64'(dut.rr_q), 64'd0);
    rst = 1'b1;
    wb_ready = 1'b1;

    // Single completion from unit 1.
    tick();
    issue(1, 32'h4040_0000, 5'd5, 1'b1);
    tick();
    #1 check("single_en_t", 64'(unit_en[1]), 64'd1);
    tick();
    #1 check("single_wb_valid", 64'(wb_valid), 64'd1);
    check("single_wb_rd", 64'(wb_bus.rd), 64'd5);
    check("single_en_t1", 64'(unit_en[1]), 64'd1);
    tick();
    #1 check("single_rr", 64'(dut.rr_q), 64'd2);
    check("single_idle", 64'(wb_valid), 64'd0);

    // Move pointer back to 0 via a unit-3 completion.
    issue(3, 32'h3F80_0000, 5'd9, 1'b1);
    tick(); tick(); tick();
    #1 check("wrap_rr", 64'(dut.rr_q), 64'd0);

    // Simultaneous completions on units 0, 2, 3.
    issue(0, 32'h4100_0000, 5'd1, 1'b1);
    issue(2, 32'h4120_0000, 5'd2, 1'b1);
    issue(3, 32'h4140_0000, 5'd3, 1'b1);
    tick();
    tick();
    #1 check("simul_t1_valid", 64'(wb_valid), 64'd1);
    check("simul_t1_en", 64'(unit_en), 64'h3);
    tick();
    #1 check("simul_t2_en3", 64'(unit_en[3]), 64'd0);
    check("simul_t2_en2", 64'(unit_en[2]), 64'd1);
    tick();
    #1 check("simul_t3_en3", 64'(unit_en[3]), 64'd1);
    check("simul_t3_valid", 64'(wb_valid), 64'd1);
    tick();
    #1 check("simul_done_busy", 64'(busy), 64'd0);

    // Back-pressure: unit 0 streams A, B, C with writeback stalled.
    wb_ready = 1'b0;
    issue(0, 32'hAAAA_0001, 5'd10, 1'b1);
    issue(0, 32'hBBBB_0002, 5'd11, 1'b1);
    issue(0, 32'hCCCC_0003, 5'd12, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      #1 check("bp_en0_low", 64'(unit_en[0]), 64'd0);
      check("bp_hold_rd", 64'(hold_rd[0]), 64'd10);
    end
    wb_ready = 1'b1;
    tick(); tick(); tick(); tick();
    #1 check("bp_done_busy", 64'(busy), 64'd0);

    // Refill without bubble: unit 2 delivers four back-to-back results.
    issue(2, 32'hD000_0001, 5'd20, 1'b1);
    issue(2, 32'hE000_0002, 5'd21, 1'b1);
    issue(2, 32'hF000_0003, 5'd22, 1'b1);
    issue(2, 32'h1000_0004, 5'd23, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      #1 check("refill_valid", 64'(wb_valid), 64'd1);
      check("refill_en2", 64'(unit_en[2]), 64'd1);
    end
    tick();
    #1 check("refill_end", 64'(wb_valid), 64'd0);

    // Flush with entries 1 and 3 valid; nothing may be written back.
    wb_ready = 1'b0;
    issue(1, 32'h5555_0001, 5'd7, 1'b0);
    issue(3, 32'h6666_0003, 5'd8, 1'b0);
    tick();
    tick();
    #1 check("pre_flush_busy", 64'(busy), 64'd1);
    check("pre_flush_flags", 64'(hold_reg_write), 64'hA);
    flush = 1'b1;
    wb_ready = 1'b1;
    #1 check("flush_clear", 64'(unit_clear), 64'hFFF);
    check("flush_wb_valid", 64'(wb_valid), 64'd0);
    tick();
    flush = 1'b0;
    #1 check("post_flush_busy", 64'(busy), 64'd0);
    check("post_flush_flags", 64'({hold_reg_write, hold_FP_reg_write}), 64'd0);
    check("post_flush_clear", 64'(unit_clear), 64'd0);

    // Reset with an entry held, then a normal completion.
    wb_ready = 1'b0;
    issue(0, 32'h7777_0000, 5'd15, 1'b0);
    tick();
    tick();
    #1 check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1 check("mid_rst_wb_valid", 64'(wb_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_en", 64'(unit_en), 64'hF);
    check("mid_rst_rr", 64'(dut.rr_q), 64'd0);
    wb_ready = 1'b1;
    issue(2, 32'h4049_0FDB, 5'd31, 1'b1);
    tick();
    tick();
    #1 check("post_rst_wb_valid", 64'(wb_valid), 64'd1);
    tick();
    tick();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
